uart_tx_arbiter: RTL and testbench

- Shares one uart_tx serializer between N_REQ byte producers, e.g. console, debug and status channels.
- Each producer gets a valid/ready byte interface. The arbiter grants producers round-robin, latches the byte and that channel's parity settings, and pulses tx_start.
- It holds tx_data, par_en and par_ty stable for the whole frame, because uart_tx samples parity controls live.
- It then tracks tx_busy to frame completion and reports a per-channel done pulse.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_arbiter_rr_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings for the uart_tx arbiter (FSM states, WAIT_HI timeout, parity type).
package uart_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT_HI = 2'd2,
    ARB_WAIT_LO = 2'd3
  } arb_state_e;
  localparam int   ARB_TIMEOUT = 3;
  localparam logic PAR_XOR     = 1'b1;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, searching last+1, last+2, ... modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [N_REQ-1:0] onehot,
  output logic [GW-1:0]    idx,
  output logic             any
);
  logic [GW-1:0] pos;
  // Walk from the farthest candidate down so the nearest valid one after last wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    pos    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = GW'((int'(last) + k) % N_REQ);
      if (req[pos]) begin
        onehot = N_REQ'(1) << pos;
        idx    = pos;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between N_REQ byte producers,
// holding the byte and parity controls stable for the whole frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   cfg_par_en,
  input  logic [N_REQ-1:0]   cfg_par_ty,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               par_en,
  output logic               par_ty,
  input  logic               tx_busy,
  output logic [GW-1:0]      gnt_id,
  output logic               arb_busy,
  output logic [N_REQ-1:0]   done
);
  arb_state_e       state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             par_en_q, par_en_d, par_ty_q, par_ty_d;
  logic             start_q, start_d, arb_busy_q, arb_busy_d;
  logic [GW-1:0]    gnt_q, gnt_d, last_q, last_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [1:0]       tmo_q, tmo_d;
  logic [N_REQ-1:0] pick_oh;
  logic [GW-1:0]    pick_idx;
  logic             pick_any, hs, finish;

  rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_pick (
    .req    (req_valid),
    .last   (last_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign hs        = (state_q == ARB_IDLE) && !tx_busy && pick_any;
  assign req_ready = hs ? pick_oh : '0;
  assign finish    = (state_q == ARB_WAIT_LO && !tx_busy) ||
                     (state_q == ARB_WAIT_HI && !tx_busy && tmo_q == 2'(ARB_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    par_en_d   = par_en_q;
    par_ty_d   = par_ty_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    arb_busy_d = finish ? 1'b0 : arb_busy_q;
    done_d     = finish ? N_REQ'(1) << gnt_q : '0;
    start_d    = hs;
    tmo_d      = (state_q == ARB_WAIT_HI) ? tmo_q + 2'd1 : 2'd0;
    case (state_q)
      ARB_IDLE: if (hs) begin
        tx_data_d  = req_data[8*int'(pick_idx) +: 8];
        par_en_d   = cfg_par_en[pick_idx];
        par_ty_d   = cfg_par_ty[pick_idx];
        gnt_d      = pick_idx;
        last_d     = pick_idx;
        arb_busy_d = 1'b1;
        state_d    = ARB_ISSUE;
      end
      ARB_ISSUE:   state_d = ARB_WAIT_HI;
      ARB_WAIT_HI: state_d = tx_busy ? ARB_WAIT_LO : (finish ? ARB_IDLE : ARB_WAIT_HI);
      ARB_WAIT_LO: state_d = finish ? ARB_IDLE : ARB_WAIT_LO;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      tx_data_q  <= '0;
      par_en_q   <= 1'b0;
      par_ty_q   <= 1'b0;
      gnt_q      <= '0;
      last_q     <= GW'(N_REQ - 1);
      arb_busy_q <= 1'b0;
      done_q     <= '0;
      start_q    <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      par_en_q   <= par_en_d;
      par_ty_q   <= par_ty_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      arb_busy_q <= arb_busy_d;
      done_q     <= done_d;
      start_q    <= start_d;
      tmo_q      <= tmo_d;
    end
  end

  assign tx_start = start_q;
  assign tx_data  = tx_data_q;
  assign par_en   = par_en_q;
  assign par_ty   = par_ty_q;
  assign gnt_id   = gnt_q;
  assign arb_busy = arb_busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed table plus corner-case sequences against a small uart_tx busy model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;
  localparam int FRAME = 6;

  logic        clk = 1'b0, rst = 1'b0;
  logic [3:0]  req_valid = '0, cfg_par_en = '0, cfg_par_ty = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready, done;
  logic        tx_start, par_en, par_ty, tx_busy, arb_busy;
  logic [7:0]  tx_data;
  logic [1:0]  gnt_id;
  logic        ext_busy = 1'b0, mute = 1'b0, par_bit;
  int          cnt;
  int          errors = 0, checks = 0;

  uart_tx_arbiter #(.N_REQ(4), .GW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_par_en(cfg_par_en), .cfg_par_ty(cfg_par_ty), .tx_start(tx_start), .tx_data(tx_data),
    .par_en(par_en), .par_ty(par_ty), .tx_busy(tx_busy), .gnt_id(gnt_id),
    .arb_busy(arb_busy), .done(done)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for FRAME cycles after tx_start, parity captured at start.
  assign tx_busy = ext_busy | (cnt != 0);
  always @(posedge clk or negedge rst)
    if (!rst) begin
      cnt     <= 0;
      par_bit <= 1'b0;
    end else if (tx_start && !mute) begin
      cnt     <= FRAME;
      par_bit <= (par_ty == PAR_XOR) ? ^tx_data : ~^tx_data;
    end else if (cnt != 0) cnt <= cnt - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = tx_start;
    end
    chk({name, "_start_seen"}, 32'(ok), 32'd1);
    chk({name, "_start_idle"}, 32'(tx_busy), 32'd0);
  endtask

  task automatic wait_done(input string name, output int cyc, output logic [3:0] d);
    d = '0;
    cyc = 0;
    for (int i = 0; i < 60 && d == 4'b0; i++) begin
      @(negedge clk);
      cyc++;
      d = done;
    end
    chk({name, "_done_seen"}, 32'(d != 4'b0), 32'd1);
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  pen, pty;
    logic [3:0]  ready;
    logic [7:0]  xdata;
    logic        xpen, xpty;
    logic [1:0]  xgnt;
  } vec_t;

  vec_t tbl[8];
  int cyc;
  logic [3:0] d, dseen;
  logic bad;

  initial begin
    tbl[0] = '{4'b0100, 32'h00A50000, 4'b0100, 4'b0000, 4'b0100, 8'hA5, 1'b1, 1'b0, 2'd2};
    tbl[1] = '{4'b1111, 32'h13121110, 4'b1010, 4'b1000, 4'b1000, 8'h13, 1'b1, 1'b1, 2'd3};
    tbl[2] = '{4'b0011, 32'h13121110, 4'b0001, 4'b0011, 4'b0001, 8'h10, 1'b1, 1'b1, 2'd0};
    tbl[3] = '{4'b0011, 32'hDEADBEEF, 4'b0000, 4'b0010, 4'b0010, 8'hBE, 1'b0, 1'b1, 2'd1};
    tbl[4] = '{4'b0001, 32'h000000C3, 4'b0001, 4'b0000, 4'b0001, 8'hC3, 1'b1, 1'b0, 2'd0};
    tbl[5] = '{4'b1001, 32'h7E000001, 4'b1000, 4'b1000, 4'b1000, 8'h7E, 1'b1, 1'b1, 2'd3};
    tbl[6] = '{4'b0110, 32'h005A3C00, 4'b0000, 4'b0000, 4'b0010, 8'h3C, 1'b0, 1'b0, 2'd1};
    tbl[7] = '{4'b1000, 32'h81000000, 4'b1000, 4'b0000, 4'b1000, 8'h81, 1'b1, 1'b0, 2'd3};

    #12;
    chk("rst_outputs", {19'd0, tx_start, tx_data, par_en, par_ty, gnt_id, arb_busy},  32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // all four valid from reset: 0,1,2,3 with one done each
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    dseen = '0;
    for (int f = 0; f < 4; f++) begin
      wait_start("all4");
      chk("all4_gnt", 32'(gnt_id), 32'(f));
      chk("all4_data", 32'(tx_data), 32'h10 + 32'(f));
      if (f == 3) req_valid = '0;
      wait_done("all4", cyc, d);
      chk("all4_done", 32'(d), 32'(4'b0001 << f));
      dseen = dseen | d;
    end
    chk("all4_done_set", 32'(dseen), 32'hF);

    foreach (tbl[r]) begin
      req_valid  = tbl[r].valid;
      req_data   = tbl[r].data;
      cfg_par_en = tbl[r].pen;
      cfg_par_ty = tbl[r].pty;
      #1 chk($sformatf("v%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
      wait_start($sformatf("v%0d", r));
      chk($sformatf("v%0d_data", r), 32'(tx_data), 32'(tbl[r].xdata));
      chk($sformatf("v%0d_pen", r), 32'(par_en), 32'(tbl[r].xpen));
      chk($sformatf("v%0d_pty", r), 32'(par_ty), 32'(tbl[r].xpty));
      chk($sformatf("v%0d_gnt", r), 32'(gnt_id), 32'(tbl[r].xgnt));
      chk($sformatf("v%0d_abusy", r), 32'(arb_busy), 32'd1);
      req_valid = '0;
      wait_done($sformatf("v%0d", r), cyc, d);
      chk($sformatf("v%0d_done", r), 32'(d), 32'(tbl[r].ready));
      chk($sformatf("v%0d_abusy_clr", r), 32'(arb_busy), 32'd0);
      if (tbl[r].xpen)
        chk($sformatf("v%0d_par", r), 32'(par_bit),
            32'(tbl[r].xpty ? ^tbl[r].xdata : ~^tbl[r].xdata));
    end

    // two channels continuously valid alternate
    req_valid = 4'b0011;
    req_data  = 32'h00002211;
    for (int f = 0; f < 4; f++) begin
      wait_start("alt");
      chk("alt_gnt", 32'(gnt_id), 32'(f % 2));
      chk("alt_data", 32'(tx_data), (f % 2) ? 32'h22 : 32'h11);
      if (f == 3) req_valid = '0;
      wait_done("alt", cyc, d);
      chk("alt_done", 32'(d), 32'(4'b0001 << (f % 2)));
    end

    // config and data changes after acceptance do not reach the frame
    req_valid  = 4'b0010;
    req_data   = 32'h00006B00;
    cfg_par_en = 4'b0010;
    cfg_par_ty = 4'b0010;
    wait_start("stab");
    cfg_par_en = '0;
    cfg_par_ty = '0;
    req_data   = '1;
    req_valid  = '0;
    bad = 1'b0;
    d = '0;
    for (int i = 0; i < 60 && d == 4'b0; i++) begin
      bad = bad | (par_en !== 1'b1) | (par_ty !== 1'b1) | (tx_data !== 8'h6B);
      @(negedge clk);
      d = done;
    end
    chk("stab_hold", 32'(bad), 32'd0);
    chk("stab_done", 32'(d), 32'b0010);
    chk("stab_par", 32'(par_bit), 32'd1);

    // external busy blocks grants
    ext_busy  = 1'b1;
    req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1 chk("ext_ready", 32'(req_ready), 32'd0);
      chk("ext_start", 32'(tx_start), 32'd0);
      @(negedge clk);
    end
    ext_busy = 1'b0;
    #1 chk("ext_release_ready", 32'(req_ready), 32'b0001);
    wait_start("ext");
    chk("ext_gnt", 32'(gnt_id), 32'd0);
    req_valid = '0;
    wait_done("ext", cyc, d);
    chk("ext_done", 32'(d), 32'b0001);

    // uart_tx never goes busy: dropped after three WAIT_HI cycles
    mute      = 1'b1;
    req_valid = 4'b0100;
    wait_start("tmo");
    req_valid = '0;
    wait_done("tmo", cyc, d);
    chk("tmo_cycles", 32'(cyc), 32'd4);
    chk("tmo_done", 32'(d), 32'b0100);
    chk("tmo_abusy", 32'(arb_busy), 32'd0);
    mute = 1'b0;

    // reset in the middle of a frame
    req_valid = 4'b0001;
    wait_start("mid");
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("mid_in_frame", 32'({arb_busy, tx_busy}), 32'b11);
    #2 rst = 1'b0;
    #1 chk("mid_rst_outputs", {19'd0, tx_start, tx_data, par_en, par_ty, gnt_id, arb_busy}, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("mid_rst_hold_done", 32'(done), 32'd0);
    rst       = 1'b1;
    req_valid = 4'b1000;
    #1 chk("mid_after_ready", 32'(req_ready), 32'b1000);
    chk("mid_after_done", 32'(done), 32'd0);
    wait_start("mid_after");
    chk("mid_after_gnt", 32'(gnt_id), 32'd3);
    req_valid = '0;
    wait_done("mid_after", cyc, d);
    chk("mid_after_done_pulse", 32'(d), 32'b1000);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
